// File: rtl/cv32e40p_wake_event_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cv32e40p_wake_pkg
//  Brief    : Shared types, constants and the acknowledge decode helper
//             for the wake event unit.
//  Revision : 1.0 - initial release
// ============================================================================
package cv32e40p_wake_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ASLEEP = 2'd2,
        WAKING = 2'd3
    } wake_state_e;

    localparam int IRQ_ID_W = 5;

    // One-hot of the acknowledged line; an invalid ack yields all zeros.
    function automatic logic [31:0] irq_onehot(input logic [IRQ_ID_W-1:0] id,
                                               input logic                valid);
        logic [31:0] v;
        v = '0;
        if (valid) begin
            v[id] = 1'b1;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cv32e40p_wake_event_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : cv32e40p_wake_event_unit_if
//  Brief    : Controller-side signal bundle of the wake event unit.
//             master = controller / interrupt source, slave = wake unit.
//  Revision : 1.0 - initial release
// ============================================================================
interface cv32e40p_wake_event_unit_if #(
    parameter int NUM_IRQ = 32,
    parameter int CNT_W   = 32
);
    import cv32e40p_wake_pkg::*;

    logic [NUM_IRQ-1:0]  irq_i;
    logic [NUM_IRQ-1:0]  irq_mask_i;
    logic                debug_req_i;
    logic                irq_ack_i;
    logic [IRQ_ID_W-1:0] irq_ack_id_i;
    logic                wfi_req_i;
    logic                core_sleep_i;
    logic                stats_clr_i;
    logic                wake_from_sleep_o;
    logic [NUM_IRQ-1:0]  irq_pending_o;
    logic                irq_req_o;
    logic [CNT_W-1:0]    sleep_cycles_o;

    modport master (
        output irq_i, irq_mask_i, debug_req_i, irq_ack_i, irq_ack_id_i,
               wfi_req_i, core_sleep_i, stats_clr_i,
        input  wake_from_sleep_o, irq_pending_o, irq_req_o, sleep_cycles_o
    );

    modport slave (
        input  irq_i, irq_mask_i, debug_req_i, irq_ack_i, irq_ack_id_i,
               wfi_req_i, core_sleep_i, stats_clr_i,
        output wake_from_sleep_o, irq_pending_o, irq_req_o, sleep_cycles_o
    );

endinterface
`default_nettype wire

// File: rtl/cv32e40p_wake_event_unit_pend_bank.sv
`default_nettype none
// ============================================================================
//  Module   : cv32e40p_irq_pend_bank
//  Brief    : Sticky interrupt pending flops. A line high sets its bit; the
//             controller acknowledge clears it. Set beats a same-cycle ack,
//             and ack ids outside the implemented lines have no effect.
//  Revision : 1.0 - initial release
// ============================================================================
module cv32e40p_irq_pend_bank
    import cv32e40p_wake_pkg::*;
#(
    parameter int NUM_IRQ = 32
) (
    input  wire logic                clk_i,
    input  wire logic                rst_n,
    input  wire logic [NUM_IRQ-1:0]  irq_i,
    input  wire logic                irq_ack_i,
    input  wire logic [IRQ_ID_W-1:0] irq_ack_id_i,
    output logic      [NUM_IRQ-1:0]  pend_q_o
);

    logic [NUM_IRQ-1:0] ack_vec;
    logic [NUM_IRQ-1:0] pend_d;
    logic [NUM_IRQ-1:0] pend_q;

    // Truncation to NUM_IRQ bits drops acks aimed at unimplemented lines.
    assign ack_vec = NUM_IRQ'(irq_onehot(irq_ack_id_i, irq_ack_i));

    // Next pending: set by the line, otherwise held until acknowledged.
    always_comb begin
        pend_d = irq_i | (pend_q & ~ack_vec);
    end

    // Pending register, cleared by reset.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_q_o = pend_q;

endmodule
`default_nettype wire

// File: rtl/cv32e40p_wake_event_unit.sv
`default_nettype none
// ============================================================================
//  Module   : cv32e40p_wake_event_unit
//  Brief    : Ungated-clock wake logic. Tracks WFI entry, latches pending
//             interrupts and requests the core clock back on an enabled
//             interrupt or debug request. wake_from_sleep_o is held for at
//             least WAKE_HOLD cycles and for as long as WFI is requested.
//             Optional sleep-cycle counter: define CV32E40P_WAKE_STATS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module cv32e40p_wake_event_unit
    import cv32e40p_wake_pkg::*;
#(
    parameter int NUM_IRQ   = 32,
    parameter int WAKE_HOLD = 2,
    parameter int CNT_W     = 32
) (
    input  wire logic                    clk_ungated_i,
    input  wire logic                    rst_n,
    cv32e40p_wake_event_unit_if.slave    bus
);

    localparam int HOLD_W = $clog2(WAKE_HOLD) + 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(WAKE_HOLD - 1);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_ARMED  = ARMED;
    localparam logic [1:0] ST_ASLEEP = ASLEEP;
    localparam logic [1:0] ST_WAKING = WAKING;

    logic [NUM_IRQ-1:0] pend_q;
    logic [1:0]         state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               irq_enabled;
    logic               wake_event;

    cv32e40p_irq_pend_bank #(
        .NUM_IRQ (NUM_IRQ)
    ) u_pend_bank (
        .clk_i        (clk_ungated_i),
        .rst_n        (rst_n),
        .irq_i        (bus.irq_i),
        .irq_ack_i    (bus.irq_ack_i),
        .irq_ack_id_i (bus.irq_ack_id_i),
        .pend_q_o     (pend_q)
    );

    assign irq_enabled = |(pend_q & bus.irq_mask_i);
    assign wake_event  = irq_enabled | bus.debug_req_i;

    // Sleep FSM next-state and wake hold counter.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.wfi_req_i) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (wake_event) begin
                    state_d = ST_WAKING;
                    hold_d  = HOLD_INIT;
                end else if (!bus.wfi_req_i) begin
                    state_d = ST_IDLE;
                end else if (bus.core_sleep_i) begin
                    state_d = ST_ASLEEP;
                end
            end
            ST_ASLEEP: begin
                if (wake_event) begin
                    state_d = ST_WAKING;
                    hold_d  = HOLD_INIT;
                end
            end
            ST_WAKING: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
                end
                if ((hold_q == '0) && !bus.wfi_req_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and hold counter registers.
    always_ff @(posedge clk_ungated_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.wake_from_sleep_o = (state_q == ST_WAKING);
    assign bus.irq_pending_o     = pend_q;
    assign bus.irq_req_o         = irq_enabled;

`ifdef CV32E40P_WAKE_STATS_EN
    logic [CNT_W-1:0] sleep_cnt_q, sleep_cnt_d;

    // Saturating ASLEEP cycle counter; clear has priority.
    always_comb begin
        sleep_cnt_d = sleep_cnt_q;
        if (bus.stats_clr_i) begin
            sleep_cnt_d = '0;
        end else if ((state_q == ST_ASLEEP) && (sleep_cnt_q != '1)) begin
            sleep_cnt_d = sleep_cnt_q + CNT_W'(1);
        end
    end

    // Sleep counter register.
    always_ff @(posedge clk_ungated_i or negedge rst_n) begin
        if (!rst_n) begin
            sleep_cnt_q <= '0;
        end else begin
            sleep_cnt_q <= sleep_cnt_d;
        end
    end

    assign bus.sleep_cycles_o = sleep_cnt_q;
`else
    logic unused_stats_clr;
    assign unused_stats_clr   = bus.stats_clr_i;
    assign bus.sleep_cycles_o = '0;
`endif

    // The controller must not withdraw WFI while the clock is gated and no
    // wake event is present.
    a_asleep_holds_wfi: assert property (@(posedge clk_ungated_i) disable iff (!rst_n)
        !((state_q == ST_ASLEEP) && !bus.wfi_req_i && !wake_event));

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_wake_event_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cv32e40p_wake_event_unit
//  Brief    : Self-checking bench: directed scenarios plus randomized traffic
//             compared every cycle against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_wake_event_unit;
    import cv32e40p_wake_pkg::*;

    localparam int NUM_IRQ   = 16;
    localparam int WAKE_HOLD = 2;
    localparam int CNT_W     = 4;
    localparam int SLEEP_MAX = (1 << CNT_W) - 1;
`ifdef CV32E40P_WAKE_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    cv32e40p_wake_event_unit_if #(.NUM_IRQ(NUM_IRQ), .CNT_W(CNT_W)) bus ();

    cv32e40p_wake_event_unit #(
        .NUM_IRQ   (NUM_IRQ),
        .WAKE_HOLD (WAKE_HOLD),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_ungated_i (clk),
        .rst_n         (rst_n),
        .bus           (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural model: where the core is in its sleep cycle.
    bit                 m_armed, m_asleep, m_waking;
    int                 m_hold_left;
    logic [NUM_IRQ-1:0] m_pend;
    int                 m_sleep;

    task automatic model_reset();
        m_armed = 0; m_asleep = 0; m_waking = 0;
        m_hold_left = 0; m_pend = '0; m_sleep = 0;
    endtask

    task automatic model_update();
        bit ev, was_asleep;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ev         = (|(m_pend & bus.irq_mask_i)) || bus.debug_req_i;
        was_asleep = m_asleep;
        if (m_waking) begin
            if (m_hold_left == 0 && !bus.wfi_req_i) m_waking = 0;
            else if (m_hold_left > 0) m_hold_left--;
        end else if (m_asleep) begin
            if (ev) begin m_asleep = 0; m_waking = 1; m_hold_left = WAKE_HOLD - 1; end
        end else if (m_armed) begin
            if (ev) begin m_armed = 0; m_waking = 1; m_hold_left = WAKE_HOLD - 1; end
            else if (!bus.wfi_req_i) m_armed = 0;
            else if (bus.core_sleep_i) begin m_armed = 0; m_asleep = 1; end
        end else if (bus.wfi_req_i) begin
            m_armed = 1;
        end
        if (bus.stats_clr_i) m_sleep = 0;
        else if (was_asleep && m_sleep < SLEEP_MAX) m_sleep++;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (bus.irq_i[i]) m_pend[i] = 1'b1;
            else if (bus.irq_ack_i && int'(bus.irq_ack_id_i) == i) m_pend[i] = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("wake", 32'(bus.wake_from_sleep_o), 32'(m_waking));
        check("pending", 32'(bus.irq_pending_o), 32'(m_pend));
        check("irq_req", 32'(bus.irq_req_o), 32'(|(m_pend & bus.irq_mask_i)));
        check("sleep_cycles", 32'(bus.sleep_cycles_o), STATS_ON ? 32'(m_sleep) : 32'd0);
    endtask

    // One cycle: inputs already driven in the negedge phase.
    task automatic step();
        #1;
        compare_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.irq_i = '0; bus.irq_mask_i = '0; bus.debug_req_i = 0;
        bus.irq_ack_i = 0; bus.irq_ack_id_i = '0; bus.wfi_req_i = 0;
        bus.core_sleep_i = 0; bus.stats_clr_i = 0;
    endtask

    initial begin
        clk = 0; rst_n = 0; n_checks = 0; n_errors = 0;
        clear_inputs();
        model_reset();
        @(negedge clk);
        step(); step();
        rst_n = 1;
        step();

        // Reset while waking: everything drops without a clock edge.
        bus.wfi_req_i = 1; bus.irq_i = 16'h0004; bus.irq_mask_i = 16'h0004;
        step();
        bus.irq_i = '0;
        step();
        check("t1_wake_before_rst", 32'(bus.wake_from_sleep_o), 32'd1);
        #2 rst_n = 0;
        #1;
        check("t1_wake_in_rst", 32'(bus.wake_from_sleep_o), 32'd0);
        check("t1_pend_in_rst", 32'(bus.irq_pending_o), 32'd0);
        check("t1_req_in_rst", 32'(bus.irq_req_o), 32'd0);
        model_reset();
        @(negedge clk);
        step();
        clear_inputs();
        rst_n = 1;
        step();
        check("t1_idle_after_rst", 32'(bus.wake_from_sleep_o), 32'd0);

        // WFI sleep and wake on irq 3.
        bus.irq_mask_i = 16'h0008; bus.wfi_req_i = 1; bus.core_sleep_i = 1;
        step(); step(); step();
        bus.irq_i = 16'h0008;
        step();
        bus.irq_i = '0;
        check("t2_wake_n1", 32'(bus.wake_from_sleep_o), 32'd0);
        step();
        check("t2_wake_n2", 32'(bus.wake_from_sleep_o), 32'd1);
        step();
        bus.wfi_req_i = 0; bus.irq_ack_i = 1; bus.irq_ack_id_i = 5'd3;
        check("t2_wake_n3", 32'(bus.wake_from_sleep_o), 32'd1);
        step();
        bus.irq_ack_i = 0; bus.core_sleep_i = 0;
        check("t2_wake_n4", 32'(bus.wake_from_sleep_o), 32'd0);
        step();

        // Masked interrupt stays pending without waking.
        bus.irq_mask_i = '0; bus.wfi_req_i = 1; bus.core_sleep_i = 1;
        step(); step();
        bus.irq_i = 16'h0020;
        step();
        bus.irq_i = '0;
        check("t3_pend5", 32'(bus.irq_pending_o), 32'h20);
        check("t3_no_wake", 32'(bus.wake_from_sleep_o), 32'd0);
        step();
        bus.irq_mask_i = 16'h0020;
        #1 check("t3_irq_req", 32'(bus.irq_req_o), 32'd1);
        step();
        check("t3_wake", 32'(bus.wake_from_sleep_o), 32'd1);
        bus.wfi_req_i = 0; bus.irq_ack_i = 1; bus.irq_ack_id_i = 5'd5; bus.core_sleep_i = 0;
        step();
        bus.irq_ack_i = 0; bus.irq_mask_i = '0;
        step(); step();

        // Set/ack collision and out-of-range ack.
        bus.irq_i = 16'h0001; bus.irq_ack_i = 1; bus.irq_ack_id_i = 5'd0;
        step();
        bus.irq_i = '0; bus.irq_ack_id_i = 5'd31;
        check("t4_set_wins", 32'(bus.irq_pending_o), 32'h1);
        step();
        check("t4_ack31_ignored", 32'(bus.irq_pending_o), 32'h1);
        bus.irq_ack_id_i = 5'd0;
        step();
        bus.irq_ack_i = 0;
        check("t4_ack0_clears", 32'(bus.irq_pending_o), 32'h0);
        step();

        // Debug request while armed, before the clock is gated.
        bus.stats_clr_i = 1;
        step();
        bus.stats_clr_i = 0; bus.wfi_req_i = 1; bus.core_sleep_i = 0;
        step();
        bus.debug_req_i = 1;
        step();
        bus.debug_req_i = 0; bus.core_sleep_i = 1;
        check("t5_wake", 32'(bus.wake_from_sleep_o), 32'd1);
        step();
        bus.wfi_req_i = 0;
        step(); step();
        check("t5_never_asleep", 32'(bus.sleep_cycles_o), 32'd0);
        step();

        // Sleep counter saturation and clear.
        bus.wfi_req_i = 1; bus.core_sleep_i = 1;
        step(); step();
        for (int i = 0; i < 20; i++) step();
        check("t6_sat", 32'(bus.sleep_cycles_o), STATS_ON ? 32'd15 : 32'd0);
        bus.stats_clr_i = 1;
        step();
        bus.stats_clr_i = 0;
        check("t6_clr", 32'(bus.sleep_cycles_o), 32'd0);
        bus.debug_req_i = 1;
        step();
        bus.debug_req_i = 0; bus.wfi_req_i = 0;
        step(); step(); step();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            bus.irq_i        = ($urandom_range(0, 3) == 0) ?
                               (NUM_IRQ'($urandom) & NUM_IRQ'($urandom) & NUM_IRQ'($urandom)) : '0;
            if ($urandom_range(0, 15) == 0)
                bus.irq_mask_i = ($urandom_range(0, 1) == 1) ? NUM_IRQ'($urandom) : '0;
            bus.debug_req_i  = ($urandom_range(0, 31) == 0);
            bus.irq_ack_i    = ($urandom_range(0, 2) == 0);
            bus.irq_ack_id_i = 5'($urandom);
            bus.core_sleep_i = 1'($urandom);
            bus.stats_clr_i  = ($urandom_range(0, 63) == 0);
            if (m_asleep) bus.wfi_req_i = 1;
            else if ($urandom_range(0, 7) == 0) bus.wfi_req_i = ~bus.wfi_req_i;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
